// File: rtl/mfhwt_pkg.sv
// Shared constants and types for the face-detection line-buffer feeder.
package mfhwt_pkg;

  localparam int unsigned LINE_W_DEF  = 160;
  localparam int unsigned NROWS_DEF   = 4;
  localparam int unsigned FRAME_H_DEF = 120;
  localparam int unsigned DW_DEF      = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN
  } state_e;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned COL_W  = cnt_w(LINE_W_DEF);
  localparam int unsigned ROW_W  = cnt_w(NROWS_DEF);
  localparam int unsigned LINE_W_CNT = cnt_w(FRAME_H_DEF);

endpackage

// File: rtl/mfhwt_row_dispatcher.sv
// Steers a raster pixel stream into NROWS line FIFOs, one line per FIFO,
// stalling the source between groups until the line buffer has drained.
module mfhwt_row_dispatcher
  import mfhwt_pkg::*;
#(
  parameter int unsigned LINE_W  = LINE_W_DEF,
  parameter int unsigned NROWS   = NROWS_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned FRAME_H = FRAME_H_DEF
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iValid,
  input  logic             iSof,
  input  logic [DW-1:0]    iData,
  output logic             oReady,
  input  logic [NROWS-1:0] iFull,
  input  logic             iEmpty,
  output logic [NROWS-1:0] oWrreq,
  output logic [DW-1:0]    oData,
  output logic             oGroupRdy,
  output logic             oFrameDone,
  output logic             oErr,
  output logic             oOvf
);

  localparam int unsigned CW = cnt_w(LINE_W);
  localparam int unsigned RW = cnt_w(NROWS);
  localparam int unsigned LW = cnt_w(FRAME_H);

  localparam logic [CW-1:0] COL_LAST  = CW'(LINE_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(NROWS - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(FRAME_H - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [LW-1:0]    line_q, line_d;
  logic [NROWS-1:0] wrreq_q, wrreq_d;
  logic [DW-1:0]    data_q, data_d;
  logic             grp_q, grp_d;
  logic             fdone_q, fdone_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

  logic accept;
  logic wr;

  function automatic logic [NROWS-1:0] onehot(input logic [RW-1:0] r);
    logic [NROWS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  assign oReady = (state_q != ST_DRAIN);
  assign accept = iValid & oReady;
  // IDLE only takes a start-of-frame pixel; row/col are already 0 there,
  // so it shares the FILL write/advance path.
  assign wr     = accept & ((state_q == ST_FILL) | ((state_q == ST_IDLE) & iSof));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    line_d  = line_q;
    wrreq_d = '0;
    data_d  = data_q;
    grp_d   = 1'b0;
    fdone_d = 1'b0;
    err_d   = err_q;
    ovf_d   = ovf_q | (|(wrreq_q & iFull));

    if (wr) begin
      wrreq_d = onehot(row_q);
      data_d  = iData;
      state_d = ST_FILL;
      // Any sof seen in FILL is misplaced: either mid-group or on the first
      // pixel of a later group (the frame's first pixel is taken in IDLE).
      if ((state_q == ST_FILL) && iSof) begin
        err_d = 1'b1;
      end
      if (col_q == COL_LAST) begin
        col_d  = '0;
        line_d = (line_q == LINE_LAST) ? '0 : line_q + LW'(1);
        if (row_q == ROW_LAST) begin
          row_d   = '0;
          state_d = ST_DRAIN;
          grp_d   = 1'b1;
          fdone_d = (line_q == LINE_LAST);
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    // wrreq_q still set means the group's final write is in flight, so an
    // iEmpty seen now predates it.
    if ((state_q == ST_DRAIN) && iEmpty && (wrreq_q == '0)) begin
      state_d = (line_q == '0) ? ST_IDLE : ST_FILL;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      line_q  <= '0;
      wrreq_q <= '0;
      data_q  <= '0;
      grp_q   <= 1'b0;
      fdone_q <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      line_q  <= line_d;
      wrreq_q <= wrreq_d;
      data_q  <= data_d;
      grp_q   <= grp_d;
      fdone_q <= fdone_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign oWrreq     = wrreq_q;
  assign oData      = data_q;
  assign oGroupRdy  = grp_q;
  assign oFrameDone = fdone_q;
  assign oErr       = err_q;
  assign oOvf       = ovf_q;

endmodule

// File: tb/tb_mfhwt_row_dispatcher.sv
// Directed bench for mfhwt_row_dispatcher with hand-derived expectations.
module tb_mfhwt_row_dispatcher;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iValid;
  logic        iSof;
  logic [15:0] iData;
  logic        oReady;
  logic [3:0]  iFull;
  logic        iEmpty;
  logic [3:0]  oWrreq;
  logic [15:0] oData;
  logic        oGroupRdy;
  logic        oFrameDone;
  logic        oErr;
  logic        oOvf;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          auto_drain = 1'b0;

  int unsigned grp_cnt = 0;
  int unsigned fd_cnt = 0;
  int unsigned fd_coinc = 0;
  int unsigned wr_cnt = 0;

  always #5 iClk = ~iClk;

  mfhwt_row_dispatcher #(
    .LINE_W (160),
    .NROWS  (4),
    .DW     (16),
    .FRAME_H(120)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iValid    (iValid),
    .iSof      (iSof),
    .iData     (iData),
    .oReady    (oReady),
    .iFull     (iFull),
    .iEmpty    (iEmpty),
    .oWrreq    (oWrreq),
    .oData     (oData),
    .oGroupRdy (oGroupRdy),
    .oFrameDone(oFrameDone),
    .oErr      (oErr),
    .oOvf      (oOvf)
  );

  always @(negedge iClk) begin
    if (oGroupRdy) grp_cnt++;
    if (oFrameDone) fd_cnt++;
    if (oFrameDone && oGroupRdy) fd_coinc++;
    if (|oWrreq) wr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    iRst   = 1'b1;
    iValid = 1'b0;
    iSof   = 1'b0;
    iData  = '0;
    iFull  = '0;
    iEmpty = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    iRst = 1'b0;
  endtask

  // Presents one pixel, waits (bounded) for oReady, returns #1 after the
  // accepting edge so the registered write is visible.
  task automatic push(input logic [15:0] d, input logic sof);
    int unsigned n;
    n      = 0;
    iValid = 1'b1;
    iData  = d;
    iSof   = sof;
    while (!oReady && n < 2000) begin
      if (auto_drain && n >= 2) iEmpty = 1'b1;
      @(posedge iClk);
      #1;
      n++;
    end
    if (auto_drain) iEmpty = 1'b0;
    if (!oReady) chk("ready_timeout", {31'b0, oReady}, 32'd1);
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    iSof   = 1'b0;
  endtask

  initial begin
    int unsigned gb, fb, cb, wb;
    logic [3:0] exp_w;

    do_reset();
    chk("rst_ready", {31'b0, oReady}, 32'd1);
    chk("rst_wrreq", {28'b0, oWrreq}, 32'd0);
    chk("rst_data", {16'b0, oData}, 32'd0);
    chk("rst_grp", {31'b0, oGroupRdy}, 32'd0);
    chk("rst_fdone", {31'b0, oFrameDone}, 32'd0);
    chk("rst_err", {31'b0, oErr}, 32'd0);
    chk("rst_ovf", {31'b0, oOvf}, 32'd0);

    // Non-sof pixels in IDLE are dropped, sof pixel lands in FIFO 0.
    for (int i = 0; i < 5; i++) begin
      push(16'(16'h0100 + i), 1'b0);
      chk("idle_drop", {28'b0, oWrreq}, 32'd0);
    end
    push(16'h0abc, 1'b1);
    chk("sof_wrreq", {28'b0, oWrreq}, 32'd1);
    chk("sof_data", {16'b0, oData}, 32'h0abc);

    // Misplaced sof at row 1 col 37; iFull[3] held high must not flag overflow.
    iFull = 4'b1000;
    for (int i = 1; i < 160 + 37; i++) begin
      push(16'(i), 1'b0);
      chk("fill_wrreq", {28'b0, oWrreq}, (i < 160) ? 32'd1 : 32'd2);
    end
    push(16'hbeef, 1'b1);
    chk("err_wrreq", {28'b0, oWrreq}, 32'd2);
    chk("err_data", {16'b0, oData}, 32'hbeef);
    chk("err_set", {31'b0, oErr}, 32'd1);
    for (int c = 38; c < 160; c++) begin
      push(16'(c), 1'b0);
      chk("err_cont", {28'b0, oWrreq}, 32'd2);
    end
    chk("no_ovf", {31'b0, oOvf}, 32'd0);

    // Overflow on FIFO 2: write still issued, flag sticks until reset.
    iFull = 4'b0100;
    push(16'h2222, 1'b0);
    chk("ovf_wrreq", {28'b0, oWrreq}, 32'd4);
    @(posedge iClk);
    #1;
    chk("ovf_set", {31'b0, oOvf}, 32'd1);
    iFull = 4'b0000;
    repeat (5) @(posedge iClk);
    #1;
    chk("ovf_sticky", {31'b0, oOvf}, 32'd1);
    chk("err_sticky", {31'b0, oErr}, 32'd1);
    do_reset();
    chk("rst2_ovf", {31'b0, oOvf}, 32'd0);
    chk("rst2_err", {31'b0, oErr}, 32'd0);
    chk("rst2_ready", {31'b0, oReady}, 32'd1);
    push(16'h0055, 1'b0);
    chk("rst2_idle", {28'b0, oWrreq}, 32'd0);

    // Continuous group of 640 pixels.
    do_reset();
    for (int i = 0; i < 640; i++) begin
      push(16'(i), (i == 0));
      exp_w = 4'b0001 << (i / 160);
      chk("grp_wrreq", {28'b0, oWrreq}, {28'b0, exp_w});
      chk("grp_data", {16'b0, oData}, i);
      chk("grp_pulse", {31'b0, oGroupRdy}, (i == 639) ? 32'd1 : 32'd0);
    end
    chk("drain_ready", {31'b0, oReady}, 32'd0);
    chk("grp_fdone", {31'b0, oFrameDone}, 32'd0);

    // Stale iEmpty while the final write is in flight is ignored.
    iEmpty = 1'b1;
    @(posedge iClk);
    #1;
    iEmpty = 1'b0;
    chk("stale_empty", {31'b0, oReady}, 32'd0);
    for (int i = 0; i < 50; i++) begin
      @(posedge iClk);
      #1;
      chk("drain_hold", {31'b0, oReady}, 32'd0);
    end
    iEmpty = 1'b1;
    @(posedge iClk);
    #1;
    iEmpty = 1'b0;
    chk("drain_exit", {31'b0, oReady}, 32'd1);
    push(16'd640, 1'b0);
    chk("next_grp", {28'b0, oWrreq}, 32'd1);

    // Full frame with random gaps and a modelled drain.
    do_reset();
    gb = grp_cnt;
    fb = fd_cnt;
    cb = fd_coinc;
    auto_drain = 1'b1;
    for (int p = 0; p < 120 * 160; p++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge iClk);
        #1;
      end
      push(16'(p), (p == 0));
      exp_w = 4'b0001 << ((p / 160) % 4);
      chk("frm_wrreq", {28'b0, oWrreq}, {28'b0, exp_w});
    end
    auto_drain = 1'b0;
    chk("frm_last_grp", {31'b0, oGroupRdy}, 32'd1);
    chk("frm_last_fd", {31'b0, oFrameDone}, 32'd1);
    @(posedge iClk);
    #1;
    chk("frm_grp_cnt", grp_cnt - gb, 32'd30);
    chk("frm_fd_cnt", fd_cnt - fb, 32'd1);
    chk("frm_fd_coinc", fd_coinc - cb, 32'd1);
    iEmpty = 1'b1;
    repeat (2) @(posedge iClk);
    #1;
    iEmpty = 1'b0;
    chk("frm_idle_ready", {31'b0, oReady}, 32'd1);
    wb = wr_cnt;
    for (int i = 0; i < 3; i++) begin
      push(16'h1234, 1'b0);
      chk("frm_idle_drop", {28'b0, oWrreq}, 32'd0);
    end
    repeat (2) @(posedge iClk);
    #1;
    chk("frm_no_writes", wr_cnt - wb, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mfhwt_row_dispatcher.md
# mfhwt_row_dispatcher

Upstream feeder for the 160x4 ping-pong line buffer in the face-detection front end. Accepts a raster pixel stream (16-bit, 160 pixels per line) over a valid/ready handshake and steers each line into one of the four line FIFOs via a one-hot write request. After four lines are written it stalls the source until the consumer has drained the buffer, then fills the next group. Counts lines per frame and flags framing errors and overflow.

## Interface

Parameters:
- LINE_W, 160: pixels per line; equals per-FIFO depth.
- NROWS, 4: lines per group; width of the write-request vector.
- DW, 16: pixel width.
- FRAME_H, 120: lines per frame; must be a multiple of NROWS.

Ports:
- iClk  in  1  clock; all logic rising-edge.
- iRst  in  1  reset, synchronous, active-high.
- iValid  in  1  source pixel valid.
- iSof  in  1  start of frame; qualifies the first pixel of a frame.
- iData  in  DW  source pixel.
- oReady  out  1  dispatcher accepts the pixel this cycle.
- iFull  in  NROWS  per-FIFO full flags from the line buffer.
- iEmpty  in  1  line buffer empty (all FIFOs read together).
- oWrreq  out  NROWS  one-hot FIFO write request.
- oData  out  DW  pixel to line buffer.
- oGroupRdy  out  1  one-cycle pulse: group of NROWS lines complete.
- oFrameDone  out  1  one-cycle pulse: last group of frame complete.
- oErr  out  1  sticky framing error.
- oOvf  out  1  sticky overflow error.

## Operation

- Accept = iValid & oReady.
- States:
  - IDLE: oReady=1. Accepted pixel with iSof=1 is written as col 0 of row 0 and moves to FILL. Accepted pixels with iSof=0 are dropped.
  - FILL: oReady=1. Each accepted pixel is written to FIFO `row`, then `col` increments. When col=LINE_W-1 is accepted, col wraps to 0 and row increments. When row NROWS-1, col LINE_W-1 is accepted, go to DRAIN.
  - DRAIN: oReady=0. Leave when iEmpty=1 and no write is pending in the output register. Then go to FILL if the frame is incomplete, otherwise IDLE.
- Counters:
  - col: 0..LINE_W-1.
  - row: 0..NROWS-1.
  - line: 0..FRAME_H-1. Increments per completed line; clears at frame end.
  - Widths are clog2 of range.
- Framing error: an accepted pixel with iSof=1 in FILL at (row,col)≠(0,0) sets oErr. The pixel is still written as ordinary data and the counters are not resynchronised. iSof=1 on the first pixel of a group other than the frame's first group also sets oErr.
- Overflow: issuing oWrreq[k] while iFull[k]=1 sets oOvf. The write is still issued; the FIFO drops it.
- oErr and oOvf clear only on iRst.

## Timing

- Write latency is 1 cycle: a pixel accepted at cycle n gives oWrreq/oData at n+1.
- oWrreq is all-zero when nothing was accepted at n.
- oData holds its last value when idle.
- oReady is decoded from registered state only, with no combinational path from iValid.
- oGroupRdy and oFrameDone are high for exactly one cycle, coincident with the final oWrreq[NROWS-1] of the group. On the last group of a frame both pulse together.
- DRAIN exit: iEmpty is sampled high at cycle m, so oReady=1 at m+1. A stale iEmpty=1 in the cycle the final write is registered is ignored (pending-write check).
- Reset values:
  - state=IDLE; row, col, line = 0.
  - oWrreq=0, oData=0.
  - oGroupRdy=0, oFrameDone=0, oErr=0, oOvf=0.
  - oReady=1 from the first cycle after reset.
- Reset mid-group returns to IDLE at once. Already-written FIFO contents are the line buffer's responsibility.

## Structure

- Shared package mfhwt_pkg holds:
  - LINE_W, NROWS, FRAME_H defaults.
  - State encoding: IDLE, FILL, DRAIN.
  - The clog2-derived counter widths.
- Single module, no sub-module. The one-hot decoder is a local function.
- Instantiated beside the 160x4 line buffer: oWrreq→iWrreq, oData→iData, iFull←oFull, iEmpty←oEmpty.

## Test plan

- Reset then a continuous stream of 640 pixels, iSof on the first, data=index → oWrreq=0001 for data 0..159, 0010 for 160..319, 0100 for 320..479, 1000 for 480..639. oGroupRdy pulses with data 639. oReady drops the next cycle.
- In DRAIN, hold iEmpty=0 for 50 cycles, then 1 → oReady=0 throughout, rises the cycle after iEmpty is sampled high. The next pixel goes to oWrreq=0001.
- Full frame of 120 lines with random iValid gaps and a model drain → 30 oGroupRdy pulses. oFrameDone coincides with the 30th. State returns to IDLE. Non-sof pixels are then dropped with no writes.
- Pixels with iSof=0 after reset, then a pixel with iSof=1 → no writes before the sof pixel. The sof pixel is written to FIFO 0 one cycle later.
- iSof=1 at row 1, col 37 → oErr=1 sticky, pixel written to FIFO 1, counters continue to col 38.
- Force iFull[2]=1 while row 2 is written → oOvf=1 sticky. oWrreq=0100 is still issued. Only iRst clears oOvf.
